// File: rtl/buf_dat_row_sched_pkg.sv
// Shared definitions for the feature-data row-fetch scheduler: row-index width and
// scheduler state encodings.
package buf_dat_row_sched_pkg;

    localparam int LOG2_H = 5;

    localparam logic [1:0] SCHED_IDLE  = 2'd0;
    localparam logic [1:0] SCHED_FETCH = 2'd1;
    localparam logic [1:0] SCHED_DONE  = 2'd2;

endpackage

// File: rtl/buf_dat_row_sched.sv
// Row-fetch scheduler for the CONV feature-data buffer: issues one DMA request per input row,
// bounds buffer occupancy and requests in flight, and reports completed rows.
module buf_dat_row_sched
    import buf_dat_row_sched_pkg::*;
#(
    parameter int HW       = LOG2_H,
    parameter int BUF_ROWS = 8,
    parameter int MAX_OUT  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fsm_logic_init,
    input  logic [HW-1:0] Hin,
    input  logic          dma_dat_reuse,
    output logic          dma_req_vld,
    input  logic          dma_req_rdy,
    output logic [HW-1:0] dma_req_row,
    input  logic          dma_done,
    input  logic          row_release,
    output logic          row_num_updt,
    output logic [HW-1:0] row_num,
    output logic          sched_busy,
    output logic          sched_done,
    output logic          err_seq
);

    localparam int            CW    = HW + 1;
    localparam logic [CW-1:0] C_BUF = CW'(BUF_ROWS);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_OUT);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    logic [1:0]    r_state;
    logic [HW-1:0] r_hin;
    logic [CW-1:0] r_iss;
    logic [CW-1:0] r_done;
    logic [CW-1:0] r_rel;
    logic [CW-1:0] r_drain;
    logic          r_updt;
    logic [HW-1:0] r_row_num;
    logic          r_err;

    logic [CW-1:0] w_out;
    logic [CW-1:0] w_pend;
    logic          w_vld;
    logic          w_hs;
    logic          w_done_any;
    logic          w_done_ok;
    logic          w_rel_ok;
    logic          w_last;

    assign w_out  = r_iss - r_done;
    assign w_pend = r_drain + w_out;

    // Stale completions from an aborted layer must drain before any new row is requested.
    assign w_vld = (r_state == SCHED_FETCH) && (r_iss < {1'b0, r_hin}) &&
                   ((r_iss - r_rel) < C_BUF) && (w_out < C_MAX) && (r_drain == '0);
    assign w_hs       = w_vld && dma_req_rdy;
    assign w_done_any = dma_done && (w_pend != '0);
    assign w_done_ok  = dma_done && (r_drain == '0) && (w_out != '0);
    assign w_rel_ok   = row_release && (r_rel < r_done);
    assign w_last     = (r_state == SCHED_FETCH) && w_done_ok && ((r_done + C_ONE) == {1'b0, r_hin});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SCHED_IDLE;
            r_hin     <= '0;
            r_iss     <= '0;
            r_done    <= '0;
            r_rel     <= '0;
            r_drain   <= '0;
            r_updt    <= 1'b0;
            r_row_num <= '0;
            r_err     <= 1'b0;
        end else if (fsm_logic_init) begin
            // Everything still in flight, including a request accepted this cycle, becomes drain.
            r_state <= (dma_dat_reuse || (Hin == '0)) ? SCHED_DONE : SCHED_FETCH;
            r_hin   <= Hin;
            r_iss   <= '0;
            r_done  <= '0;
            r_rel   <= '0;
            r_drain <= w_pend + CW'(w_hs) - CW'(w_done_any);
            r_updt  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_updt <= w_done_ok;
            if (w_hs)
                r_iss <= r_iss + C_ONE;
            if (w_done_ok) begin
                r_done    <= r_done + C_ONE;
                r_row_num <= r_done[HW-1:0];
            end
            if (dma_done && (r_drain != '0))
                r_drain <= r_drain - C_ONE;
            if (w_rel_ok)
                r_rel <= r_rel + C_ONE;
            if ((dma_done && (w_pend == '0)) || (row_release && !w_rel_ok))
                r_err <= 1'b1;
            if (w_last)
                r_state <= SCHED_DONE;
        end
    end

    assign dma_req_vld  = w_vld;
    assign dma_req_row  = r_iss[HW-1:0];
    assign row_num_updt = r_updt;
    assign row_num      = r_row_num;
    assign sched_busy   = (r_state == SCHED_FETCH);
    assign sched_done   = (r_state == SCHED_DONE);
    assign err_seq      = r_err;

endmodule

// File: tb/tb_buf_dat_row_sched.sv
// Self-checking bench for buf_dat_row_sched: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_buf_dat_row_sched;
    import buf_dat_row_sched_pkg::*;

    localparam int HW = LOG2_H;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fsm_logic_init;
    logic [HW-1:0] Hin;
    logic          dma_dat_reuse;
    logic          dma_req_vld;
    logic          dma_req_rdy;
    logic [HW-1:0] dma_req_row;
    logic          dma_done;
    logic          row_release;
    logic          row_num_updt;
    logic [HW-1:0] row_num;
    logic          sched_busy;
    logic          sched_done;
    logic          err_seq;

    buf_dat_row_sched #(.HW(HW), .BUF_ROWS(8), .MAX_OUT(2)) dut (
        .clk(clk), .rst_n(rst_n), .fsm_logic_init(fsm_logic_init), .Hin(Hin),
        .dma_dat_reuse(dma_dat_reuse), .dma_req_vld(dma_req_vld), .dma_req_rdy(dma_req_rdy),
        .dma_req_row(dma_req_row), .dma_done(dma_done), .row_release(row_release),
        .row_num_updt(row_num_updt), .row_num(row_num), .sched_busy(sched_busy),
        .sched_done(sched_done), .err_seq(err_seq)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr_in();
        fsm_logic_init = 1'b0; Hin = '0; dma_dat_reuse = 1'b0;
        dma_req_rdy = 1'b0; dma_done = 1'b0; row_release = 1'b0;
    endtask

    // ---------------- reference model: outstanding requests tagged by layer generation
    int m_gen, m_iss, m_dn, m_rel, m_hin, m_mode, m_rnum;
    int q[$];
    bit m_updt, m_err;

    function automatic bit m_vld();
        return (m_mode == 1) && (m_iss < m_hin) && ((m_iss - m_rel) < 8) &&
               ((m_iss - m_dn) < 2) && (q.size() == (m_iss - m_dn));
    endfunction

    task automatic m_reset();
        m_gen = 0; m_iss = 0; m_dn = 0; m_rel = 0; m_hin = 0; m_mode = 0; m_rnum = 0;
        m_updt = 0; m_err = 0; q.delete();
    endtask

    task automatic m_step(input bit init, input int hin, input bit reuse, input bit rdy,
                          input bit dn_in, input bit rel_in);
        bit hs;
        int dn_old;
        int f;
        hs = m_vld() && rdy;
        dn_old = m_dn;
        if (init) begin
            if (dn_in && q.size() > 0) void'(q.pop_front());
            if (hs) q.push_back(m_gen);
            m_gen++;
            m_iss = 0; m_dn = 0; m_rel = 0; m_hin = hin;
            m_mode = (reuse || hin == 0) ? 2 : 1;
            m_updt = 0; m_err = 0;
        end else begin
            m_updt = 0;
            if (dn_in) begin
                if (q.size() == 0) m_err = 1;
                else begin
                    f = q.pop_front();
                    if (f == m_gen) begin
                        m_rnum = m_dn; m_dn++; m_updt = 1;
                        if (m_mode == 1 && m_dn == m_hin) m_mode = 2;
                    end
                end
            end
            if (hs) begin q.push_back(m_gen); m_iss++; end
            if (rel_in) begin
                if (m_rel < dn_old) m_rel++;
                else m_err = 1;
            end
        end
    endtask

    task automatic do_reset();
        clr_in();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        m_reset();
    endtask

    // ---------------- directed vector table
    typedef struct packed {
        logic init; logic [HW-1:0] hin; logic reuse; logic rdy; logic done; logic rel;
        logic vld; logic [HW-1:0] row; logic updt; logic [HW-1:0] rnum;
        logic busy; logic sdone; logic err;
    } vec_t;

    function automatic vec_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9, a10, a11, a12);
        vec_t v;
        v.init = 1'(a0); v.hin = HW'(a1); v.reuse = 1'(a2); v.rdy = 1'(a3);
        v.done = 1'(a4); v.rel = 1'(a5); v.vld = 1'(a6); v.row = HW'(a7);
        v.updt = 1'(a8); v.rnum = HW'(a9); v.busy = 1'(a10); v.sdone = 1'(a11); v.err = 1'(a12);
        return v;
    endfunction

    vec_t tv[15];

    initial begin
        int hs, dn, upd, mx, cnt;
        bit b_init, b_reuse, b_rdy, b_dn, b_rel;
        int h;

        //            init hin reu rdy dn rel | vld row upd rnum busy sdone err
        tv[0]  = mk(1,  4, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(0,  0, 0, 1, 0, 0,   1, 0, 0, 0, 1, 0, 0);
        tv[2]  = mk(0,  0, 0, 1, 0, 0,   1, 1, 0, 0, 1, 0, 0);
        tv[3]  = mk(0,  0, 0, 1, 1, 0,   0, 2, 0, 0, 1, 0, 0);
        tv[4]  = mk(0,  0, 0, 1, 1, 0,   1, 2, 1, 0, 1, 0, 0);
        tv[5]  = mk(0,  0, 0, 1, 0, 0,   1, 3, 1, 1, 1, 0, 0);
        tv[6]  = mk(0,  0, 0, 1, 1, 0,   0, 4, 0, 1, 1, 0, 0);
        tv[7]  = mk(0,  0, 0, 1, 1, 0,   0, 4, 1, 2, 1, 0, 0);
        tv[8]  = mk(0,  0, 0, 0, 0, 0,   0, 4, 1, 3, 0, 1, 0);
        tv[9]  = mk(1, 10, 1, 0, 0, 0,   0, 4, 0, 3, 0, 1, 0);
        tv[10] = mk(0,  0, 0, 0, 1, 0,   0, 0, 0, 3, 0, 1, 0);
        tv[11] = mk(0,  0, 0, 0, 0, 1,   0, 0, 0, 3, 0, 1, 1);
        tv[12] = mk(1,  0, 0, 0, 0, 0,   0, 0, 0, 3, 0, 1, 1);
        tv[13] = mk(0,  0, 0, 0, 0, 1,   0, 0, 0, 3, 0, 1, 0);
        tv[14] = mk(0,  0, 0, 0, 0, 0,   0, 0, 0, 3, 0, 1, 1);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("v%0d_vld", i), dma_req_vld, tv[i].vld);
            if (tv[i].vld) chk($sformatf("v%0d_row", i), dma_req_row, tv[i].row);
            chk($sformatf("v%0d_updt", i), row_num_updt, tv[i].updt);
            chk($sformatf("v%0d_rnum", i), row_num, tv[i].rnum);
            chk($sformatf("v%0d_busy", i), sched_busy, tv[i].busy);
            chk($sformatf("v%0d_sdone", i), sched_done, tv[i].sdone);
            chk($sformatf("v%0d_err", i), err_seq, tv[i].err);
            fsm_logic_init = tv[i].init; Hin = tv[i].hin; dma_dat_reuse = tv[i].reuse;
            dma_req_rdy = tv[i].rdy; dma_done = tv[i].done; row_release = tv[i].rel;
            tick();
        end
        clr_in();

        // ---- buffer-full limit, then one release admits row 8; stall keeps request stable
        do_reset();
        fsm_logic_init = 1'b1; Hin = HW'(12);
        tick();
        clr_in();
        hs = 0; dn = 0; upd = 0; mx = 0;
        for (int c = 0; c < 40; c++) begin
            if (row_num_updt) upd++;
            dma_req_rdy = 1'b1;
            dma_done = (hs - dn) > 0;
            if (dma_done) dn++;
            if (dma_req_vld) hs++;
            if ((hs - dn) > mx) mx = hs - dn;
            tick();
        end
        clr_in();
        chk("full_issued", hs, 8);
        chk("full_vld", dma_req_vld, 0);
        chk("full_updts", upd, 8);
        chk("full_rnum", row_num, 7);
        chk("full_maxout", mx <= 2, 1);
        row_release = 1'b1;
        tick();
        row_release = 1'b0;
        chk("rel_vld", dma_req_vld, 1);
        chk("rel_row", dma_req_row, 8);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_vld", dma_req_vld, 1);
            chk("stall_row", dma_req_row, 8);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld", dma_req_vld, 0);
        chk("arst_busy", sched_busy, 0);
        chk("arst_rnum", row_num, 0);
        chk("arst_sdone", sched_done, 0);
        tick();
        rst_n = 1'b1;

        // ---- abort with two requests in flight
        do_reset();
        fsm_logic_init = 1'b1; Hin = HW'(6);
        tick();
        clr_in();
        dma_req_rdy = 1'b1;
        repeat (4) tick();
        chk("abort_pre_vld", dma_req_vld, 0);
        dma_req_rdy = 1'b0;
        fsm_logic_init = 1'b1; Hin = HW'(6);
        tick();
        fsm_logic_init = 1'b0;
        chk("abort_vld0", dma_req_vld, 0);
        chk("abort_busy", sched_busy, 1);
        dma_done = 1'b1;
        tick();
        chk("drain1_updt", row_num_updt, 0);
        chk("drain1_vld", dma_req_vld, 0);
        tick();
        dma_done = 1'b0;
        chk("drain2_updt", row_num_updt, 0);
        chk("drain2_vld", dma_req_vld, 1);
        chk("drain2_row", dma_req_row, 0);
        chk("drain2_err", err_seq, 0);
        dma_req_rdy = 1'b1;
        tick();
        dma_req_rdy = 1'b0;
        chk("new_row1", dma_req_row, 1);
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        chk("new_updt", row_num_updt, 1);
        chk("new_rnum", row_num, 0);

        // ---- randomized traffic against the reference model
        do_reset();
        cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_vld", dma_req_vld, m_vld());
            if (m_vld()) chk("rnd_row", dma_req_row, m_iss);
            chk("rnd_updt", row_num_updt, m_updt);
            chk("rnd_rnum", row_num, m_rnum);
            chk("rnd_busy", sched_busy, m_mode == 1);
            chk("rnd_sdone", sched_done, m_mode == 2);
            chk("rnd_err", err_seq, m_err);
            b_init  = ($urandom % 50) == 0;
            h       = $urandom_range(0, 20);
            b_reuse = ($urandom % 6) == 0;
            b_rdy   = ($urandom % 10) < 7;
            b_dn    = (q.size() > 0) ? (($urandom % 10) < 4) : (($urandom % 50) == 0);
            b_rel   = (m_rel < m_dn) ? (($urandom % 10) < 3) : (($urandom % 50) == 0);
            if (b_init) cnt++;
            fsm_logic_init = b_init; Hin = HW'(h); dma_dat_reuse = b_reuse;
            dma_req_rdy = b_rdy; dma_done = b_dn; row_release = b_rel;
            m_step(b_init, h, b_reuse, b_rdy, b_dn, b_rel);
            tick();
        end
        clr_in();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
